// File: rtl/ctrl_sequencer.sv
// Five-state instruction sequencer: fetches 9-bit words, drives ALU/register
// controls, executes branches and data-memory load/store, and halts on opcode 15.
module ctrl_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       imem_rd,
  output logic [7:0] imem_addr,
  input  logic       imem_valid,
  input  logic [8:0] imem_data,
  output logic [3:0] alu_instruction,
  output logic       alu_direction,
  output logic       alu_use_carry,
  output logic       alu_carry_in,
  input  logic       alu_carry_out,
  input  logic [1:0] alu_compare,
  output logic [2:0] reg_sel,
  output logic       reg_wr_en,
  output logic       dmem_rd,
  output logic       dmem_wr,
  input  logic       dmem_ack,
  output logic [7:0] pc,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [8:0] ir_q, ir_d;
  logic       carry_q, carry_d;
  logic [1:0] cmp_q, cmp_d;

  logic [3:0] opcode;
  logic [4:0] operand;
  logic [7:0] offset;
  logic       br_taken;

  assign opcode  = ir_q[8:5];
  assign operand = ir_q[4:0];
  assign offset  = {{3{operand[4]}}, operand};

  assign pc        = pc_q;
  assign imem_addr = pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= 8'd0;
      ir_q    <= 9'd0;
      carry_q <= 1'b0;
      cmp_q   <= 2'b11;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
      cmp_q   <= cmp_d;
    end
  end

  // Compare encoding: 10 eq, 01 gt, 00 lt; 11 (reset value) never matches.
  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      4'd9:    br_taken = (cmp_q == 2'b10);
      4'd10:   br_taken = (cmp_q == 2'b01);
      4'd11:   br_taken = (cmp_q == 2'b00);
      4'd12:   br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    carry_d = carry_q;
    cmp_d   = cmp_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = 8'd0;
          carry_d = 1'b0;
          cmp_d   = 2'b11;
        end
      end
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if ((opcode == 4'd2) || (opcode == 4'd3) || (opcode == 4'd4) || (opcode == 4'd8)) begin
          carry_d = alu_carry_out;
        end
        if (opcode == 4'd7) begin
          cmp_d = alu_compare;
        end
        case (opcode)
          4'd13, 4'd14: state_d = S_MEM;
          4'd15:        state_d = S_HALT;
          4'd9, 4'd10, 4'd11, 4'd12: begin
            state_d = S_FETCH;
            pc_d    = br_taken ? (pc_q + offset) : (pc_q + 8'd1);
          end
          default: begin
            state_d = S_FETCH;
            pc_d    = pc_q + 8'd1;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_d = S_FETCH;
          pc_d    = pc_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from registered state; only the load write strobe follows dmem_ack.
  always_comb begin
    imem_rd         = 1'b0;
    alu_instruction = 4'd0;
    alu_direction   = 1'b0;
    alu_use_carry   = 1'b0;
    alu_carry_in    = 1'b0;
    reg_sel         = 3'd0;
    reg_wr_en       = 1'b0;
    dmem_rd         = 1'b0;
    dmem_wr         = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_rd = 1'b1;
        busy    = 1'b1;
      end
      S_EXEC: begin
        busy            = 1'b1;
        alu_instruction = opcode;
        alu_direction   = operand[4];
        alu_use_carry   = operand[3];
        alu_carry_in    = carry_q;
        reg_sel         = operand[2:0];
        reg_wr_en       = (opcode <= 4'd6);
      end
      S_MEM: begin
        busy            = 1'b1;
        alu_instruction = opcode;
        alu_direction   = operand[4];
        alu_use_carry   = operand[3];
        alu_carry_in    = carry_q;
        reg_sel         = operand[2:0];
        dmem_wr         = (opcode == 4'd13);
        dmem_rd         = (opcode == 4'd14);
        reg_wr_en       = (opcode == 4'd14) && dmem_ack;
      end
      S_HALT: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule
